// File: rtl/stopwatch_timer_counter_pkg.sv
// Shared widths and default wrap limits for the stopwatch time base.
package timer_pkg;

  localparam int unsigned MS_W    = 10;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned MS_MAX  = 999;
  localparam int unsigned SEC_MAX = 59;

endpackage : timer_pkg

// File: rtl/stopwatch_timer_counter_if.sv
// Control/count bundle between prescaler, stopwatch counter and display logic.
interface stopwatch_timer_counter_if;
  import timer_pkg::*;

  logic             I_EN_1MS;
  logic             I_CLEAR_EN;
  logic             I_START_EN;
  logic [MS_W-1:0]  O_TIMER_MS;
  logic [SEC_W-1:0] O_TIMER_SEC;

  modport master (
    output I_EN_1MS,
    output I_CLEAR_EN,
    output I_START_EN,
    input  O_TIMER_MS,
    input  O_TIMER_SEC
  );

  modport slave (
    input  I_EN_1MS,
    input  I_CLEAR_EN,
    input  I_START_EN,
    output O_TIMER_MS,
    output O_TIMER_SEC
  );

endinterface : stopwatch_timer_counter_if

// File: rtl/stopwatch_timer_counter_mod_counter.sv
// Modulo-(MAX+1) counter with synchronous clear and a combinational carry-out.
module mod_counter #(
  parameter int unsigned W   = 10,
  parameter int unsigned MAX = 999
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap_c
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // >= rather than == so a stray out-of-range value still wraps on the next tick
  always_comb begin
    count_d = count_q;
    wrap_c  = inc && (count_q >= MAX_V);
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = wrap_c ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : mod_counter

// File: rtl/stopwatch_timer_counter.sv
// Stopwatch time base: ms (0..MS_MAX) carrying into seconds (0..SEC_MAX) on 1 ms ticks.
module stopwatch_timer_counter #(
  parameter int unsigned MS_MAX  = timer_pkg::MS_MAX,
  parameter int unsigned SEC_MAX = timer_pkg::SEC_MAX
) (
  input  logic                        I_CLK,
  input  logic                        I_RSTN,
  stopwatch_timer_counter_if.slave    bus
);

  localparam int unsigned MS_W  = timer_pkg::MS_W;
  localparam int unsigned SEC_W = timer_pkg::SEC_W;

  logic             ms_inc_c;
  logic             ms_wrap_c;
  logic             sec_wrap_unused_c;
  logic [MS_W-1:0]  ms_count;
  logic [SEC_W-1:0] sec_count;

  assign ms_inc_c = bus.I_START_EN & bus.I_EN_1MS;

  mod_counter #(
    .W   (MS_W),
    .MAX (MS_MAX)
  ) u_ms (
    .clk    (I_CLK),
    .rst_n  (I_RSTN),
    .clr    (bus.I_CLEAR_EN),
    .inc    (ms_inc_c),
    .count  (ms_count),
    .wrap_c (ms_wrap_c)
  );

  // Seconds advance only on the edge where milliseconds roll over
  mod_counter #(
    .W   (SEC_W),
    .MAX (SEC_MAX)
  ) u_sec (
    .clk    (I_CLK),
    .rst_n  (I_RSTN),
    .clr    (bus.I_CLEAR_EN),
    .inc    (ms_wrap_c),
    .count  (sec_count),
    .wrap_c (sec_wrap_unused_c)
  );

  assign bus.O_TIMER_MS  = ms_count;
  assign bus.O_TIMER_SEC = sec_count;

endmodule : stopwatch_timer_counter

// File: tb/tb_stopwatch_timer_counter.sv
// Directed bench for the stopwatch time base with hand-computed ms/sec values.
module tb_stopwatch_timer_counter;

  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_errors;

  stopwatch_timer_counter_if bus_if ();

  stopwatch_timer_counter u_dut (
    .I_CLK  (clk),
    .I_RSTN (rst_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input int unsigned sec, input int unsigned ms);
    check({tag, ".sec"}, 32'(bus_if.O_TIMER_SEC), 32'(sec));
    check({tag, ".ms"},  32'(bus_if.O_TIMER_MS),  32'(ms));
  endtask

  // Hold the tick high for n consecutive edges
  task automatic tick_n(input int unsigned n);
    @(negedge clk);
    bus_if.I_EN_1MS = 1'b1;
    repeat (n) @(negedge clk);
    bus_if.I_EN_1MS = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus_if.I_EN_1MS   = 1'b0;
    bus_if.I_CLEAR_EN = 1'b0;
    bus_if.I_START_EN = 1'b0;

    // Reset with random inputs for 100 ns
    repeat (10) begin
      @(negedge clk);
      bus_if.I_EN_1MS   = 1'($urandom);
      bus_if.I_CLEAR_EN = 1'($urandom);
      bus_if.I_START_EN = 1'($urandom);
    end
    #1;
    check_time("reset", 0, 0);

    @(negedge clk);
    bus_if.I_EN_1MS   = 1'b0;
    bus_if.I_CLEAR_EN = 1'b0;
    bus_if.I_START_EN = 1'b0;
    rst_n = 1'b1;
    repeat (10) begin
      tick_n(1);
      @(negedge clk);
    end
    check_time("idle_ticks", 0, 0);

    // Basic count: one tick every 16 cycles
    bus_if.I_START_EN = 1'b1;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      bus_if.I_EN_1MS = 1'b1;
      if (i == 0) begin
        #1;
        check("no_comb_path", 32'(bus_if.O_TIMER_MS), 32'd0);
      end
      @(negedge clk);
      bus_if.I_EN_1MS = 1'b0;
      if (i == 0) check("first_tick_latency", 32'(bus_if.O_TIMER_MS), 32'd1);
      repeat (14) @(negedge clk);
    end
    check_time("basic_250", 0, 250);

    // Carry from ms into seconds
    tick_n(749);
    check_time("tick_999", 0, 999);
    tick_n(1);
    check_time("carry_1000", 1, 0);

    // Pause at 3.100: ticks while stopped are lost
    tick_n(2100);
    check_time("pre_pause", 3, 100);
    bus_if.I_START_EN = 1'b0;
    repeat (50) begin
      tick_n(1);
      @(negedge clk);
    end
    check_time("paused", 3, 100);
    bus_if.I_START_EN = 1'b1;
    repeat (5) begin
      tick_n(1);
      @(negedge clk);
    end
    check_time("resumed", 3, 105);

    // Clear beats a simultaneous tick
    tick_n(9240);
    check_time("pre_clear", 12, 345);
    @(negedge clk);
    bus_if.I_CLEAR_EN = 1'b1;
    bus_if.I_EN_1MS   = 1'b1;
    @(negedge clk);
    bus_if.I_EN_1MS   = 1'b0;
    check_time("clear_vs_tick", 0, 0);
    repeat (5) begin
      tick_n(1);
      @(negedge clk);
    end
    check_time("clear_held", 0, 0);
    bus_if.I_CLEAR_EN = 1'b0;

    // Full wrap 59.999 -> 0.000 in one tick
    tick_n(59999);
    check_time("pre_wrap", 59, 999);
    tick_n(1);
    check_time("full_wrap", 0, 0);

    // Asynchronous reset mid-cycle, then resume from zero
    tick_n(7);
    check_time("pre_async", 0, 7);
    bus_if.I_EN_1MS = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_time("async_reset", 0, 0);
    @(negedge clk);
    @(negedge clk);
    check_time("reset_held", 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    bus_if.I_EN_1MS = 1'b0;
    check_time("first_after_release", 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_stopwatch_timer_counter
